// File: rtl/rv_iopmp_entry_bram_arbiter_pkg.sv
// Shared types for the IOPMP entry BRAM arbiter: scan FSM states and the streamed entry beat.
package rv_iopmp_entry_bram_arbiter_pkg;

  localparam int unsigned NumEntries = 8;
  localparam int unsigned BramDwidth = 128;
  localparam int unsigned EntryAw    = $clog2(NumEntries);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StFlush
  } scan_state_e;

  typedef struct packed {
    logic [BramDwidth-1:0] data;
    logic [EntryAw-1:0]    idx;
    logic                  last;
  } entry_beat_t;

endpackage

// File: rtl/rv_iopmp_entry_skid.sv
// Two-deep valid/ready buffer of entry beats; flush drops all contents and any concurrent push.
module rv_iopmp_entry_skid
  import rv_iopmp_entry_bram_arbiter_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  entry_beat_t push_beat_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output entry_beat_t out_beat_o,
  output logic [1:0]  count_o
);

  entry_beat_t mem_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;
  logic        pop;

  assign out_valid_o = (count_q != 2'd0);
  assign out_beat_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign pop         = out_valid_o & out_ready_i;

  // The producer never pushes into a full buffer, so no overflow guard is needed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_beat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(push_i) - 2'(pop);
    end
  end

endmodule

// File: rtl/rv_iopmp_entry_bram_arbiter.sv
// Owns the single-port entry BRAM: config port always wins, a scan sequencer streams entry
// ranges to the checker around it and reports whether a config write overlapped the scan.
module rv_iopmp_entry_bram_arbiter
  import rv_iopmp_entry_bram_arbiter_pkg::*;
#(
  parameter int unsigned NUMBER_ENTRIES = NumEntries,
  parameter int unsigned BRAM_DWIDTH    = BramDwidth,
  localparam int unsigned AW            = $clog2(NUMBER_ENTRIES)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_we_i,
  input  logic                     cfg_en_i,
  input  logic [AW-1:0]            cfg_addr_i,
  input  logic [BRAM_DWIDTH-1:0]   cfg_din_i,
  input  logic [BRAM_DWIDTH/8-1:0] cfg_be_i,
  output logic [BRAM_DWIDTH-1:0]   cfg_dout_o,
  input  logic                     scan_req_valid_i,
  output logic                     scan_req_ready_o,
  input  logic [AW-1:0]            scan_start_i,
  input  logic [AW:0]              scan_count_i,
  input  logic                     scan_abort_i,
  output logic                     entry_valid_o,
  input  logic                     entry_ready_i,
  output logic [BRAM_DWIDTH-1:0]   entry_data_o,
  output logic [AW-1:0]            entry_idx_o,
  output logic                     entry_last_o,
  output logic                     scan_done_o,
  output logic                     scan_dirty_o,
  output logic                     bram_we_o,
  output logic                     bram_en_o,
  output logic [AW-1:0]            bram_addr_o,
  output logic [BRAM_DWIDTH-1:0]   bram_din_o,
  output logic [BRAM_DWIDTH/8-1:0] bram_be_o,
  input  logic [BRAM_DWIDTH-1:0]   bram_dout_i
);

  // One spare bit over AW+1 keeps start + count from overflowing.
  localparam int unsigned IW = AW + 2;

  scan_state_e   state_q, state_d;
  logic [IW-1:0] next_idx_q, end_idx_q;
  logic [IW-1:0] start_x, count_x, remain, eff_cnt, end_x;
  logic [AW-1:0] inflight_idx_q;
  logic          inflight_q, dirty_q, done_q, empty_q;
  logic          accept, cfg_wr, scanning, issue, last_issue, push, pop, pop_last, flush;
  logic [1:0]    skid_count, occ;
  entry_beat_t   push_beat, out_beat;

  assign cfg_wr   = cfg_en_i & cfg_we_i;
  assign scanning = (state_q == StScan) || (state_q == StDrain);
  assign accept   = scan_req_valid_i && (state_q == StIdle);
  assign flush    = scanning && scan_abort_i;

  always_comb begin
    start_x = IW'(scan_start_i);
    count_x = IW'(scan_count_i);
    remain  = (start_x < IW'(NUMBER_ENTRIES)) ? IW'(NUMBER_ENTRIES) - start_x : '0;
    eff_cnt = (count_x < remain) ? count_x : remain;
    end_x   = start_x + eff_cnt;
  end

  // Occupancy counts the beat leaving this cycle as free so a held-high ready sees no bubble.
  assign pop        = entry_valid_o & entry_ready_i;
  assign occ        = 2'(inflight_q) + skid_count - 2'(pop);
  assign issue      = (state_q == StScan) && !cfg_en_i && !scan_abort_i && (occ < 2'd2);
  assign last_issue = issue && ((next_idx_q + IW'(1)) == end_idx_q);
  assign push       = inflight_q && scanning;
  assign pop_last   = pop && out_beat.last;

  always_comb begin
    push_beat      = '0;
    push_beat.data = bram_dout_i;
    push_beat.idx  = inflight_idx_q;
    push_beat.last = (IW'(inflight_idx_q) == (end_idx_q - IW'(1)));
  end

  rv_iopmp_entry_skid u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .push_i      (push),
    .push_beat_i (push_beat),
    .out_valid_o (entry_valid_o),
    .out_ready_i (entry_ready_i),
    .out_beat_o  (out_beat),
    .count_o     (skid_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && (eff_cnt != '0)) state_d = StScan;
      StScan: begin
        if (scan_abort_i)    state_d = inflight_q ? StFlush : StIdle;
        else if (last_issue) state_d = StDrain;
      end
      StDrain: begin
        if (scan_abort_i)  state_d = inflight_q ? StFlush : StIdle;
        else if (pop_last) state_d = StIdle;
      end
      StFlush: if (!inflight_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      next_idx_q     <= '0;
      end_idx_q      <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      dirty_q        <= 1'b0;
      done_q         <= 1'b0;
      empty_q        <= 1'b0;
    end else begin
      if (accept) begin
        next_idx_q <= start_x;
        end_idx_q  <= end_x;
      end else if (issue) begin
        next_idx_q <= next_idx_q + IW'(1);
      end
      inflight_q <= issue;
      if (issue) inflight_idx_q <= next_idx_q[AW-1:0];
      if (accept)                 dirty_q <= cfg_wr;
      else if (state_q != StIdle) dirty_q <= dirty_q | cfg_wr;
      done_q  <= (accept && (eff_cnt == '0)) ||
                 (pop_last && !scan_abort_i && (state_q == StDrain));
      empty_q <= accept && (eff_cnt == '0);
    end
  end

  always_comb begin
    bram_en_o   = 1'b0;
    bram_we_o   = 1'b0;
    bram_addr_o = '0;
    bram_din_o  = '0;
    bram_be_o   = '0;
    if (cfg_en_i) begin
      bram_en_o   = 1'b1;
      bram_we_o   = cfg_we_i;
      bram_addr_o = cfg_addr_i;
      bram_din_o  = cfg_din_i;
      bram_be_o   = cfg_be_i;
    end else if (issue) begin
      bram_en_o   = 1'b1;
      bram_addr_o = next_idx_q[AW-1:0];
    end
  end

  assign scan_req_ready_o = (state_q == StIdle);
  assign cfg_dout_o       = bram_dout_i;
  assign entry_data_o     = out_beat.data;
  assign entry_idx_o      = out_beat.idx;
  assign entry_last_o     = out_beat.last;
  assign scan_done_o      = done_q;
  // A write landing in the done cycle itself still marks the scan dirty.
  assign scan_dirty_o     = done_q && !empty_q && (dirty_q || cfg_wr);

endmodule

// File: tb/tb_rv_iopmp_entry_bram_arbiter.sv
// Directed bench for rv_iopmp_entry_bram_arbiter with a behavioural 1-cycle-latency BRAM.
module tb_rv_iopmp_entry_bram_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 128;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_we = 1'b0, cfg_en = 1'b0;
  logic [AW-1:0]   cfg_addr = '0;
  logic [DW-1:0]   cfg_din = '0;
  logic [DW/8-1:0] cfg_be = '0;
  logic [DW-1:0]   cfg_dout;
  logic            scan_req_valid = 1'b0, scan_req_ready;
  logic [AW-1:0]   scan_start = '0;
  logic [AW:0]     scan_count = '0;
  logic            scan_abort = 1'b0;
  logic            entry_valid, entry_ready = 1'b1, entry_last;
  logic [DW-1:0]   entry_data;
  logic [AW-1:0]   entry_idx;
  logic            scan_done, scan_dirty;
  logic            bram_we, bram_en;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_din;
  logic [DW/8-1:0] bram_be;
  logic [DW-1:0]   bram_dout = '0;

  always #5 clk = ~clk;

  rv_iopmp_entry_bram_arbiter dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cfg_we_i         (cfg_we),
    .cfg_en_i         (cfg_en),
    .cfg_addr_i       (cfg_addr),
    .cfg_din_i        (cfg_din),
    .cfg_be_i         (cfg_be),
    .cfg_dout_o       (cfg_dout),
    .scan_req_valid_i (scan_req_valid),
    .scan_req_ready_o (scan_req_ready),
    .scan_start_i     (scan_start),
    .scan_count_i     (scan_count),
    .scan_abort_i     (scan_abort),
    .entry_valid_o    (entry_valid),
    .entry_ready_i    (entry_ready),
    .entry_data_o     (entry_data),
    .entry_idx_o      (entry_idx),
    .entry_last_o     (entry_last),
    .scan_done_o      (scan_done),
    .scan_dirty_o     (scan_dirty),
    .bram_we_o        (bram_we),
    .bram_en_o        (bram_en),
    .bram_addr_o      (bram_addr),
    .bram_din_o       (bram_din),
    .bram_be_o        (bram_be),
    .bram_dout_i      (bram_dout)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  // BRAM model, reloaded with the initial pattern while reset is held.
  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= init_word(i);
    end else if (bram_en) begin
      if (bram_we)
        for (int b = 0; b < DW / 8; b++)
          if (bram_be[b]) mem[bram_addr][b*8+:8] <= bram_din[b*8+:8];
      bram_dout <= mem[bram_addr];
    end
  end

  // Stream monitor: accepted beats, done pulses and reads outstanding toward the checker.
  int            cyc = 0;
  int            q_idx[$];
  logic [DW-1:0] q_data[$];
  bit            q_last[$];
  int            q_cyc[$];
  int            done_cnt = 0, done_cyc = 0, outst = 0;
  bit            done_dirty = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bram_en && !cfg_en) outst = outst + 1;
      if (entry_valid && entry_ready) begin
        outst = outst - 1;
        q_idx.push_back(int'(entry_idx));
        q_data.push_back(entry_data);
        q_last.push_back(entry_last);
        q_cyc.push_back(cyc);
      end
      if (scan_done) begin
        done_cnt   = done_cnt + 1;
        done_cyc   = cyc;
        done_dirty = scan_dirty;
      end
    end
  end

  int            errors = 0, checks = 0;
  logic [DW-1:0] ref_mem [N];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input logic [AW-1:0] s, input logic [AW:0] c);
    scan_req_valid = 1'b1;
    scan_start     = s;
    scan_count     = c;
    tick();
    scan_req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == base) check({tag, " done timeout"}, 128'(0), 128'(1));
    tick();
  endtask

  task automatic check_stream(input string tag, input int bq, input int start, input int n);
    check({tag, " beats"}, 128'(q_idx.size() - bq), 128'(n));
    for (int k = 0; k < n && bq + k < q_idx.size(); k++) begin
      check($sformatf("%s idx%0d", tag, k), 128'(q_idx[bq+k]), 128'(start + k));
      check($sformatf("%s data%0d", tag, k), q_data[bq+k], ref_mem[start+k]);
      check($sformatf("%s last%0d", tag, k), 128'(q_last[bq+k]), 128'(k == n - 1));
    end
  endtask

  initial begin
    int bq, bd;
    logic [DW-1:0] new5;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bq, bd;
    logic [DW-1:0] new5;
    for (int i = 0; i < N; i++) ref_mem[i] = init_word(i);
    tick();
    tick();
    @(negedge clk);
    check("rst ready", 128'(scan_req_ready), 128'(1));
    check("rst valid", 128'(entry_valid), 128'(0));
    check("rst done", 128'(scan_done), 128'(0));
    check("rst bram_en", 128'(bram_en), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // 1: start=2 count=4, back-to-back beats, done one cycle after last beat
    bq = q_idx.size(); bd = done_cnt;
    start_scan(3'd2, 4'd4);
    wait_done("t1", bd, 40);
    check_stream("t1", bq, 2, 4);
    if (q_idx.size() - bq == 4) begin
      check("t1 back-to-back", 128'(q_cyc[bq+3] - q_cyc[bq]), 128'(3));
      check("t1 done latency", 128'(done_cyc - q_cyc[bq+3]), 128'(1));
    end
    check("t1 done count", 128'(done_cnt - bd), 128'(1));
    check("t1 dirty", 128'(done_dirty), 128'(0));

    // 2: full scan with a config read of entry 6 three cycles in
    bq = q_idx.size(); bd = done_cnt;
    start_scan(3'd0, 4'd8);
    tick();
    tick();
    cfg_en = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd6;
    @(negedge clk);
    check("t2 bram_en", 128'(bram_en), 128'(1));
    check("t2 bram_we", 128'(bram_we), 128'(0));
    check("t2 bram_addr", 128'(bram_addr), 128'(6));
    tick();
    cfg_en = 1'b0;
    @(negedge clk);
    check("t2 cfg_dout", cfg_dout, ref_mem[6]);
    wait_done("t2", bd, 60);
    check_stream("t2", bq, 0, 8);

    // 3: ready low for 10 cycles once the first beat is presented
    bq = q_idx.size(); bd = done_cnt;
    start_scan(3'd0, 4'd8);
    tick();
    tick();
    entry_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("t3 stalled valid", 128'(entry_valid), 128'(1));
    check("t3 stalled idx", 128'(entry_idx), 128'(0));
    check("t3 stalled data", entry_data, ref_mem[0]);
    check("t3 outstanding", 128'(outst), 128'(2));
    tick();
    entry_ready = 1'b1;
    wait_done("t3", bd, 60);
    check_stream("t3", bq, 0, 8);

    // 4: config write of entry 5 during a scan marks it dirty; a rescan sees the new data
    new5 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bq = q_idx.size(); bd = done_cnt;
    start_scan(3'd0, 4'd8);
    tick();
    cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd5; cfg_din = new5; cfg_be = 16'hFFFF;
    @(negedge clk);
    check("t4 bram_we", 128'(bram_we), 128'(1));
    check("t4 bram_be", 128'(bram_be), 128'(16'hFFFF));
    tick();
    cfg_en = 1'b0; cfg_we = 1'b0;
    ref_mem[5] = new5;
    wait_done("t4", bd, 60);
    check("t4 beats", 128'(q_idx.size() - bq), 128'(8));
    check("t4 dirty", 128'(done_dirty), 128'(1));
    bq = q_idx.size(); bd = done_cnt;
    start_scan(3'd5, 4'd1);
    wait_done("t4 rescan", bd, 20);
    check_stream("t4 rescan", bq, 5, 1);
    check("t4 rescan dirty", 128'(done_dirty), 128'(0));

    // partial byte-enable write then config read back
    cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd1; cfg_din = '1; cfg_be = 16'h000F;
    tick();
    cfg_we = 1'b0;
    ref_mem[1] = {init_word(1)[127:32], 32'hFFFF_FFFF};
    tick();
    cfg_en = 1'b0;
    @(negedge clk);
    check("be partial", cfg_dout, ref_mem[1]);
    tick();

    // 5: clipped range and empty scan
    bq = q_idx.size(); bd = done_cnt;
    start_scan(3'd6, 4'd5);
    wait_done("t5", bd, 30);
    check_stream("t5", bq, 6, 2);
    bq = q_idx.size(); bd = done_cnt;
    start_scan(3'd3, 4'd0);
    @(negedge clk);
    check("t5 empty done", 128'(scan_done), 128'(1));
    check("t5 empty dirty", 128'(scan_dirty), 128'(0));
    repeat (3) tick();
    check("t5 empty beats", 128'(q_idx.size() - bq), 128'(0));
    check("t5 empty done count", 128'(done_cnt - bd), 128'(1));

    // 6: abort with one read in flight, then reset mid-scan
    bq = q_idx.size(); bd = done_cnt;
    start_scan(3'd0, 4'd8);
    tick();
    scan_abort = 1'b1;
    @(negedge clk);
    check("t6 no issue on abort", 128'(bram_en), 128'(0));
    tick();
    scan_abort = 1'b0;
    @(negedge clk);
    check("t6 flush ready", 128'(scan_req_ready), 128'(0));
    check("t6 flush valid", 128'(entry_valid), 128'(0));
    tick();
    @(negedge clk);
    check("t6 ready back", 128'(scan_req_ready), 128'(1));
    repeat (5) tick();
    check("t6 abort beats", 128'(q_idx.size() - bq), 128'(0));
    check("t6 abort done", 128'(done_cnt - bd), 128'(0));

    start_scan(3'd0, 4'd8);
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("t6 rst valid", 128'(entry_valid), 128'(0));
    check("t6 rst ready", 128'(scan_req_ready), 128'(1));
    check("t6 rst bram_en", 128'(bram_en), 128'(0));
    check("t6 rst done", 128'(scan_done), 128'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) ref_mem[i] = init_word(i);
    bq = q_idx.size(); bd = done_cnt;
    repeat (5) tick();
    check("t6 post-rst beats", 128'(q_idx.size() - bq), 128'(0));
    check("t6 post-rst done", 128'(done_cnt - bd), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
